// File: rtl/aska_npg_pkg.sv
// Shared definitions for the neural pulse generator and its bus monitor.
// Holds the monitor FSM state encoding, default counter widths, the gap
// timeout and the H-bridge switch / DAC widths that the generator also uses.
package aska_npg_pkg;

    // Observed bus widths (shared with the generator).
    localparam int SW_W  = 4;
    localparam int DAC_W = 6;

    // Default monitor counter widths and gap limit.
    localparam int PH_W_DEF    = 4;
    localparam int PER_W_DEF   = 13;
    localparam int CNT_W_DEF   = 8;
    localparam int GAP_MAX_DEF = 15;

    // Monitor FSM encoding.
    typedef enum logic [1:0] {
        ST_REST = 2'd0,
        ST_POS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_NEG  = 2'd3
    } npg_state_t;

endpackage

// File: rtl/aska_sat_counter.sv
// Saturating up-counter.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous clear to zero (highest priority)
//   load        : synchronous load of load_val
//   en          : increment, holding at all-ones once reached
//   count       : registered count
module aska_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/aska_npg_monitor.sv
// Passive decoder of the H-bridge control bus of the neural pulse generator.
// Rebuilds each biphasic pulse (positive width, interphase gap, negative
// width, pulse period, DAC code) and raises sticky safety faults.
//   clk, resetn        : clock, asynchronous active-low reset
//   up_switches        : observed P-switch enables
//   down_switches      : observed N-switch enables
//   dac                : observed DAC code
//   clear              : synchronous clear of sticky faults, pulse_count,
//                        period_valid
//   pos/gap/neg_width  : cycle counts of the last reported pulse
//   pulse_dac          : DAC code on the last positive-phase cycle
//   period             : cycles between the last two pulse starts
//   period_valid       : period holds a real measurement
//   meas_valid         : one-cycle strobe, width outputs just updated
//   pulse_count        : completed pulses since reset/clear (saturating)
//   fault_*            : sticky fault flags
//   fsm_state          : debug view of the decoder FSM state
//
// Handshake: there is no back-pressure. meas_valid is a pure strobe that is
// high for exactly the one cycle in which the width/pulse_dac registers first
// show the new pulse; those registers then hold until the next strobe.
module aska_npg_monitor
    import aska_npg_pkg::*;
#(
    parameter int PH_W    = PH_W_DEF,
    parameter int PER_W   = PER_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SW_W-1:0]  up_switches,
    input  logic [SW_W-1:0]  down_switches,
    input  logic [DAC_W-1:0] dac,
    input  logic             clear,
    output logic [PH_W-1:0]  pos_width,
    output logic [PH_W-1:0]  gap_width,
    output logic [PH_W-1:0]  neg_width,
    output logic [DAC_W-1:0] pulse_dac,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             meas_valid,
    output logic [CNT_W-1:0] pulse_count,
    output logic             fault_short,
    output logic             fault_imbalance,
    output logic             fault_polarity,
    output logic             fault_gap_timeout,
    output logic [1:0]       fsm_state
);

    // The gap counter is compared before it increments, so the timeout fires
    // on the idle cycle that would bring it to GAP_MAX.
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_MAX - 1);

    npg_state_t       state;
    logic [SW_W-1:0]  up_pat, down_pat;   // positive-phase pattern
    logic [SW_W-1:0]  neg_up, neg_down;   // pattern seen on entering NEG
    logic [DAC_W-1:0] dac_hold;
    logic             has_start;          // a pulse start seen since reset/clear

    logic [PH_W-1:0]  pos_cnt, gap_cnt, neg_cnt;
    logic [PER_W-1:0] per_cnt;

    logic             act, pat_match, pat_swap, neg_hold;
    logic             start, done, gap_expire;
    logic             pos_en, gap_load, gap_en, neg_load, neg_en;
    logic [PH_W-1:0]  gap_load_val;
    logic             set_short, set_pol, set_imb;
    logic [PER_W-1:0] period_next;

    always_comb begin
        act        = (up_switches | down_switches) != '0;
        pat_match  = (up_switches == up_pat) && (down_switches == down_pat);
        pat_swap   = (up_switches == down_pat) && (down_switches == up_pat);
        neg_hold   = (up_switches == neg_up) && (down_switches == neg_down);

        start      = (state == ST_REST) && act;
        done       = (state == ST_NEG) && !act;
        gap_expire = (state == ST_GAP) && !act && (gap_cnt >= GAP_LAST);

        pos_en       = (state == ST_POS) && pat_match;
        // Leaving POS: an idle cycle opens a gap of 1, an immediate
        // reversal means there was no gap at all.
        gap_load     = (state == ST_POS) && !pat_match;
        gap_load_val = act ? '0 : PH_W'(1);
        gap_en       = (state == ST_GAP) && !act && !gap_expire;
        neg_load     = ((state == ST_POS) && act && !pat_match) ||
                       ((state == ST_GAP) && act);
        neg_en       = (state == ST_NEG) && act;

        set_short  = (up_switches & down_switches) != '0;
        set_pol    = ((state == ST_POS) && act && !pat_match && !pat_swap) ||
                     ((state == ST_GAP) && act && !pat_swap) ||
                     ((state == ST_NEG) && act && !neg_hold);
        set_imb    = done && (pos_cnt != neg_cnt);

        period_next = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
    end

    aska_sat_counter #(.W(PH_W)) u_pos_cnt (
        .clk(clk), .resetn(resetn), .clr(1'b0), .load(start),
        .load_val(PH_W'(1)), .en(pos_en), .count(pos_cnt)
    );

    aska_sat_counter #(.W(PH_W)) u_gap_cnt (
        .clk(clk), .resetn(resetn), .clr(1'b0), .load(gap_load),
        .load_val(gap_load_val), .en(gap_en), .count(gap_cnt)
    );

    aska_sat_counter #(.W(PH_W)) u_neg_cnt (
        .clk(clk), .resetn(resetn), .clr(1'b0), .load(neg_load),
        .load_val(PH_W'(1)), .en(neg_en), .count(neg_cnt)
    );

    // Free-running; restarts at 0 on the cycle a pulse starts.
    aska_sat_counter #(.W(PER_W)) u_per_cnt (
        .clk(clk), .resetn(resetn), .clr(start), .load(1'b0),
        .load_val('0), .en(1'b1), .count(per_cnt)
    );

    aska_sat_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk(clk), .resetn(resetn), .clr(clear), .load(1'b0),
        .load_val('0), .en(done), .count(pulse_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_REST;
            up_pat            <= '0;
            down_pat          <= '0;
            neg_up            <= '0;
            neg_down          <= '0;
            dac_hold          <= '0;
            has_start         <= 1'b0;
            pos_width         <= '0;
            gap_width         <= '0;
            neg_width         <= '0;
            pulse_dac         <= '0;
            period            <= '0;
            period_valid      <= 1'b0;
            meas_valid        <= 1'b0;
            fault_short       <= 1'b0;
            fault_imbalance   <= 1'b0;
            fault_polarity    <= 1'b0;
            fault_gap_timeout <= 1'b0;
        end else begin
            meas_valid <= done;

            // A fault condition in the clear cycle keeps the flag set.
            fault_short       <= set_short  | (fault_short       & ~clear);
            fault_imbalance   <= set_imb    | (fault_imbalance   & ~clear);
            fault_polarity    <= set_pol    | (fault_polarity    & ~clear);
            fault_gap_timeout <= gap_expire | (fault_gap_timeout & ~clear);

            if (clear) begin
                has_start    <= 1'b0;
                period_valid <= 1'b0;
            end
            // A start coinciding with clear counts as the first start.
            if (start) begin
                has_start <= 1'b1;
                if (has_start && !clear) begin
                    period       <= period_next;
                    period_valid <= 1'b1;
                end
            end

            if (start || pos_en) begin
                dac_hold <= dac;
            end

            if (done) begin
                pos_width <= pos_cnt;
                gap_width <= gap_cnt;
                neg_width <= neg_cnt;
                pulse_dac <= dac_hold;
            end

            case (state)
                ST_REST: begin
                    if (act) begin
                        state    <= ST_POS;
                        up_pat   <= up_switches;
                        down_pat <= down_switches;
                    end
                end
                ST_POS: begin
                    if (!act) begin
                        state <= ST_GAP;
                    end else if (!pat_match) begin
                        state    <= ST_NEG;
                        neg_up   <= up_switches;
                        neg_down <= down_switches;
                    end
                end
                ST_GAP: begin
                    if (act) begin
                        state    <= ST_NEG;
                        neg_up   <= up_switches;
                        neg_down <= down_switches;
                    end else if (gap_expire) begin
                        state <= ST_REST;
                    end
                end
                ST_NEG: begin
                    if (!act) begin
                        state <= ST_REST;
                    end
                end
                default: state <= ST_REST;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_aska_npg_monitor.sv
// Bench for aska_npg_monitor: directed table of pulses, hand-written corner
// sequences, then random pulse trains checked against a per-pulse model.
module tb_aska_npg_monitor;
    import aska_npg_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  up_switches = '0;
    logic [3:0]  down_switches = '0;
    logic [5:0]  dac = '0;
    logic        clear = 1'b0;
    logic [3:0]  pos_width, gap_width, neg_width;
    logic [5:0]  pulse_dac;
    logic [12:0] period;
    logic        period_valid, meas_valid;
    logic [7:0]  pulse_count;
    logic        fault_short, fault_imbalance, fault_polarity, fault_gap_timeout;
    logic [1:0]  fsm_state;

    aska_npg_monitor dut (
        .clk(clk), .resetn(resetn),
        .up_switches(up_switches), .down_switches(down_switches),
        .dac(dac), .clear(clear),
        .pos_width(pos_width), .gap_width(gap_width), .neg_width(neg_width),
        .pulse_dac(pulse_dac), .period(period), .period_valid(period_valid),
        .meas_valid(meas_valid), .pulse_count(pulse_count),
        .fault_short(fault_short), .fault_imbalance(fault_imbalance),
        .fault_polarity(fault_polarity), .fault_gap_timeout(fault_gap_timeout),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int meas_cnt = 0;

    // Per-pulse model state.
    int prev_start = 0;
    bit prev_ok    = 1'b0;
    int m_period   = 0;
    bit m_pv       = 1'b0;
    int m_count    = 0;
    bit m_imb      = 1'b0;
    bit m_gto      = 1'b0;

    typedef struct {
        int pos; int gap; int neg; int dacv;
        int per; int pv; int cnt; int imb;
    } meas_t;
    meas_t exp_q[$];
    meas_t last_exp;
    bit    sb_en = 1'b0;

    typedef struct {
        int pl; int gl; int nl;
        logic [3:0] u; logic [3:0] d; logic [5:0] v;
        int e_pos; int e_gap; int e_neg; int e_imb; int e_cnt;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] u, input logic [3:0] d, input logic [5:0] v);
        up_switches   = u;
        down_switches = d;
        dac           = v;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        prev_ok = 1'b0; m_period = 0; m_pv = 1'b0;
        m_count = 0; m_imb = 1'b0; m_gto = 1'b0;
        exp_q.delete();
    endtask

    task automatic note_start();
        if (prev_ok) begin
            m_period = (cyc - prev_start > 8191) ? 8191 : cyc - prev_start;
            m_pv = 1'b1;
        end
        prev_start = cyc;
        prev_ok    = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(4'b0, 4'b0, 6'd0);
        clear = 1'b0;
        prev_ok = 1'b0; m_pv = 1'b0; m_count = 0; m_imb = 1'b0; m_gto = 1'b0;
    endtask

    // Whole pulse: pl positive cycles, gl idle cycles, nl reversed cycles.
    // The cycle that ends the pulse is driven by the caller.
    task automatic run_pulse(input int pl, input int gl, input int nl,
                             input logic [3:0] u, input logic [3:0] d,
                             input logic [5:0] v);
        note_start();
        for (int i = 0; i < pl; i++) drive(u, d, v);
        for (int i = 0; i < gl; i++) drive(4'b0, 4'b0, v);
        for (int i = 0; i < nl; i++) drive(d, u, v);
        if (gl >= GAP_MAX_DEF) begin
            m_gto = 1'b1;
        end else if (nl > 0) begin
            last_exp.pos  = (pl > 15) ? 15 : pl;
            last_exp.gap  = gl;
            last_exp.neg  = (nl > 15) ? 15 : nl;
            last_exp.dacv = int'(v);
            m_count = (m_count == 255) ? 255 : m_count + 1;
            if (last_exp.pos != last_exp.neg) m_imb = 1'b1;
            last_exp.per = m_period;
            last_exp.pv  = int'(m_pv);
            last_exp.cnt = m_count;
            last_exp.imb = int'(m_imb);
            if (sb_en) exp_q.push_back(last_exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (resetn && meas_valid) begin
            meas_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_meas: got strobe expected none (t=%0t)", $time);
                end else begin
                    meas_t e;
                    e = exp_q.pop_front();
                    check("sb_pos",    int'(pos_width),       e.pos);
                    check("sb_gap",    int'(gap_width),       e.gap);
                    check("sb_neg",    int'(neg_width),       e.neg);
                    check("sb_dac",    int'(pulse_dac),       e.dacv);
                    check("sb_pv",     int'(period_valid),    e.pv);
                    if (e.pv != 0) check("sb_period", int'(period), e.per);
                    check("sb_count",  int'(pulse_count),     e.cnt);
                    check("sb_imb",    int'(fault_imbalance), e.imb);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pos"},   int'(pos_width), 0);
        check({tag, "_gap"},   int'(gap_width), 0);
        check({tag, "_neg"},   int'(neg_width), 0);
        check({tag, "_dac"},   int'(pulse_dac), 0);
        check({tag, "_per"},   int'(period), 0);
        check({tag, "_pv"},    int'(period_valid), 0);
        check({tag, "_mv"},    int'(meas_valid), 0);
        check({tag, "_cnt"},   int'(pulse_count), 0);
        check({tag, "_short"}, int'(fault_short), 0);
        check({tag, "_imb"},   int'(fault_imbalance), 0);
        check({tag, "_pol"},   int'(fault_polarity), 0);
        check({tag, "_gto"},   int'(fault_gap_timeout), 0);
        check({tag, "_state"}, int'(fsm_state), int'(ST_REST));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int m0;
        logic [3:0] ru, rd;

        vt[0] = '{3,  1,  3, 4'b0001, 4'b0010, 6'd20, 3,  1,  3, 0, 1};
        vt[1] = '{3,  0,  3, 4'b0100, 4'b1000, 6'd33, 3,  0,  3, 0, 2};
        vt[2] = '{5, 14,  5, 4'b0011, 4'b0100, 6'd7,  5, 14,  5, 0, 3};
        vt[3] = '{20, 2, 17, 4'b1000, 4'b0001, 6'd63, 15, 2, 15, 0, 4};
        vt[4] = '{3,  1,  2, 4'b0001, 4'b0010, 6'd12, 3,  1,  2, 1, 5};

        // Reset
        resetn = 1'b0;
        drive(4'b0, 4'b0, 6'd0);
        drive(4'b0, 4'b0, 6'd0);
        check_all_zero("reset");
        resetn = 1'b1;
        model_reset();
        drive(4'b0, 4'b0, 6'd0);

        // Table of clean / boundary pulses
        for (int k = 0; k < 5; k++) begin
            run_pulse(vt[k].pl, vt[k].gl, vt[k].nl, vt[k].u, vt[k].d, vt[k].v);
            drive(4'b0, 4'b0, vt[k].v);
            check("tbl_mv",    int'(meas_valid), 1);
            check("tbl_pos",   int'(pos_width), vt[k].e_pos);
            check("tbl_gap",   int'(gap_width), vt[k].e_gap);
            check("tbl_neg",   int'(neg_width), vt[k].e_neg);
            check("tbl_dac",   int'(pulse_dac), int'(vt[k].v));
            check("tbl_cnt",   int'(pulse_count), vt[k].e_cnt);
            check("tbl_imb",   int'(fault_imbalance), vt[k].e_imb);
            check("tbl_pol",   int'(fault_polarity), 0);
            check("tbl_short", int'(fault_short), 0);
            check("tbl_pv",    int'(period_valid), int'(m_pv));
            check("tbl_per",   int'(period), m_period);
            check("tbl_state", int'(fsm_state), int'(ST_REST));
            drive(4'b0, 4'b0, 6'd0);
            check("tbl_mv_once", int'(meas_valid), 0);
            drive(4'b0, 4'b0, 6'd0);
        end

        // Loopback-style train: 3/1/3 pulses every 401 cycles
        run_pulse(3, 1, 3, 4'b0001, 4'b0100, 6'd20);
        for (int i = 0; i < 394; i++) drive(4'b0, 4'b0, 6'd0);
        run_pulse(3, 1, 3, 4'b0001, 4'b0100, 6'd20);
        drive(4'b0, 4'b0, 6'd0);
        check("lb_mv",  int'(meas_valid), 1);
        check("lb_per", int'(period), 401);
        check("lb_pv",  int'(period_valid), 1);
        check("lb_dac", int'(pulse_dac), 20);
        check("lb_pos", int'(pos_width), 3);
        check("lb_neg", int'(neg_width), 3);
        drive(4'b0, 4'b0, 6'd0);

        // Clear: sticky imbalance, count and period_valid drop; period stays
        check("pre_clr_imb", int'(fault_imbalance), 1);
        do_clear();
        check("clr_imb", int'(fault_imbalance), 0);
        check("clr_cnt", int'(pulse_count), 0);
        check("clr_pv",  int'(period_valid), 0);
        check("clr_per", int'(period), 401);
        check("clr_pos", int'(pos_width), 3);

        // Bridge short, then clear while the short persists
        note_start();
        drive(4'b0011, 4'b0010, 6'd0);
        check("short_set", int'(fault_short), 1);
        clear = 1'b1;
        drive(4'b0011, 4'b0010, 6'd0);
        clear = 1'b0;
        check("short_clr_wins", int'(fault_short), 1);
        for (int i = 0; i < 16; i++) drive(4'b0, 4'b0, 6'd0);
        do_clear();
        check("short_cleared", int'(fault_short), 0);
        check("gto_cleared",   int'(fault_gap_timeout), 0);

        // Gap timeout boundary: 14 idle cycles are fine, the 15th faults
        m0 = meas_cnt;
        note_start();
        for (int i = 0; i < 3; i++) drive(4'b0001, 4'b0010, 6'd5);
        for (int i = 0; i < 14; i++) drive(4'b0, 4'b0, 6'd5);
        check("gto_14",       int'(fault_gap_timeout), 0);
        check("gto_14_state", int'(fsm_state), int'(ST_GAP));
        drive(4'b0, 4'b0, 6'd5);
        check("gto_15",       int'(fault_gap_timeout), 1);
        check("gto_15_state", int'(fsm_state), int'(ST_REST));
        drive(4'b0, 4'b0, 6'd0);
        drive(4'b0, 4'b0, 6'd0);
        check("gto_no_meas", meas_cnt - m0, 0);
        run_pulse(3, 1, 3, 4'b0001, 4'b0010, 6'd9);
        drive(4'b0, 4'b0, 6'd0);
        check("gto_next_mv",  int'(meas_valid), 1);
        check("gto_next_pos", int'(pos_width), 3);
        check("gto_next_gap", int'(gap_width), 1);
        check("gto_next_neg", int'(neg_width), 3);
        check("gto_next_pv",  int'(period_valid), 1);
        check("gto_next_per", int'(period), m_period);
        drive(4'b0, 4'b0, 6'd0);

        // Polarity: negative phase is not the mirror of the positive one
        note_start();
        drive(4'b0001, 4'b0010, 6'd3);
        drive(4'b0001, 4'b0010, 6'd3);
        drive(4'b0, 4'b0, 6'd3);
        drive(4'b0100, 4'b0010, 6'd3);
        drive(4'b0100, 4'b0010, 6'd3);
        drive(4'b0, 4'b0, 6'd0);
        check("pol_set", int'(fault_polarity), 1);
        check("pol_mv",  int'(meas_valid), 1);
        check("pol_neg", int'(neg_width), 2);
        check("pol_cnt", int'(pulse_count), 2);
        drive(4'b0, 4'b0, 6'd0);

        // Reset in the middle of NEG
        note_start();
        for (int i = 0; i < 3; i++) drive(4'b0001, 4'b0010, 6'd11);
        drive(4'b0, 4'b0, 6'd11);
        drive(4'b0010, 4'b0001, 6'd11);
        drive(4'b0010, 4'b0001, 6'd11);
        check("pre_rst_state", int'(fsm_state), int'(ST_NEG));
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        up_switches = 4'b0; down_switches = 4'b0;
        model_reset();
        drive(4'b0, 4'b0, 6'd0);
        resetn = 1'b1;
        drive(4'b0, 4'b0, 6'd0);
        run_pulse(3, 1, 3, 4'b0001, 4'b0010, 6'd44);
        drive(4'b0, 4'b0, 6'd0);
        check("post_rst_mv",  int'(meas_valid), 1);
        check("post_rst_pos", int'(pos_width), 3);
        check("post_rst_dac", int'(pulse_dac), 44);
        check("post_rst_cnt", int'(pulse_count), 1);
        check("post_rst_pv",  int'(period_valid), 0);
        for (int i = 0; i < 4; i++) drive(4'b0, 4'b0, 6'd0);
        run_pulse(3, 1, 3, 4'b0001, 4'b0010, 6'd44);
        drive(4'b0, 4'b0, 6'd0);
        check("post_rst_pv2",  int'(period_valid), 1);
        check("post_rst_per2", int'(period), 12);

        // Random pulse trains against the per-pulse model
        do_clear();
        sb_en = 1'b1;
        m0 = meas_cnt;
        for (int n = 0; n < 60; n++) begin
            ru = 4'($urandom_range(1, 14));
            rd = 4'($urandom_range(1, 15)) & ~ru;
            if (rd == 4'b0) rd = ~ru;
            if ($urandom_range(0, 7) == 0) begin
                run_pulse($urandom_range(1, 18), $urandom_range(15, 18), 0,
                          ru, rd, 6'($urandom_range(0, 63)));
            end else begin
                run_pulse($urandom_range(1, 18), $urandom_range(0, 14),
                          $urandom_range(1, 18), ru, rd, 6'($urandom_range(0, 63)));
            end
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) drive(4'b0, 4'b0, 6'd0);
        end
        drive(4'b0, 4'b0, 6'd0);
        drive(4'b0, 4'b0, 6'd0);
        sb_en = 1'b0;
        check("rnd_q_empty", exp_q.size(), 0);
        check("rnd_meas",    meas_cnt - m0, m_count);
        check("rnd_cnt",     int'(pulse_count), m_count);
        check("rnd_imb",     int'(fault_imbalance), int'(m_imb));
        check("rnd_gto",     int'(fault_gap_timeout), int'(m_gto));
        check("rnd_pol",     int'(fault_polarity), 0);
        check("rnd_short",   int'(fault_short), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aska_npg_monitor.md
Name: aska_npg_monitor

Overview:
- Passive observer on the H-bridge control bus (up_switches, down_switches, DAC code) of the neural pulse generator, working as the decoder side of the stimulation waveform.
- Reconstructs each biphasic pulse: positive phase width, interphase gap, negative phase width, pulse period and DAC code.
- Flags safety faults: bridge short, charge imbalance, polarity error, missing negative phase.
- Sits beside the generator for on-chip self-test and for register readback.

Parameters:
PH_W, 4, width of phase and gap counters (saturating)
PER_W, 13, width of the period counter (saturating; 4096 cycles covers a 4.88 Hz setting)
CNT_W, 8, width of the pulse counter (saturating)
GAP_MAX, 15, gap cycles allowed before fault_gap_timeout

Ports:
clk  in  1  system clock, same domain as the generator
resetn  in  1  asynchronous, active-low reset
up_switches  in  4  observed P-switch enables
down_switches  in  4  observed N-switch enables
dac  in  6  observed DAC code
clear  in  1  synchronous; clears sticky faults, pulse_count, period_valid
pos_width  out  PH_W  cycles in last positive phase
gap_width  out  PH_W  cycles in last interphase gap
neg_width  out  PH_W  cycles in last negative phase
pulse_dac  out  6  DAC code sampled on last positive-phase cycle
period  out  PER_W  cycles between the last two pulse starts
period_valid  out  1  period holds a real measurement
meas_valid  out  1  one-cycle strobe: width and pulse_dac outputs updated
pulse_count  out  CNT_W  completed pulses since reset/clear
fault_short  out  1  sticky
fault_imbalance  out  1  sticky
fault_polarity  out  1  sticky
fault_gap_timeout  out  1  sticky

Behaviour:
- All inputs are synchronous to clk; there are no synchronisers. Every output is registered.
- Reset: every output is 0 and the FSM is in REST.
- Define active = (up_switches|down_switches) != 0.
- FSM states are REST, POS, GAP and NEG.
  - REST: on active, go to POS. Latch up_pat/down_pat = inputs. pos_cnt=1. Load the period capture (see below).
  - POS: if the inputs equal the latched pattern, pos_cnt++.
    - On !active, go to GAP with gap_cnt=1.
    - On the swapped pattern (up==down_pat, down==up_pat), go to NEG with gap=0 and neg_cnt=1.
    - On any other nonzero pattern, set fault_polarity and go to NEG with neg_cnt=1.
    - Sample dac every POS cycle into a holding register.
  - GAP: while !active, gap_cnt++.
    - If gap_cnt reaches GAP_MAX, set fault_gap_timeout and go to REST. No meas_valid.
    - On active, go to NEG with neg_cnt=1. If the pattern is not the swapped pattern, set fault_polarity.
  - NEG: while active, neg_cnt++. A pattern change inside NEG sets fault_polarity.
    - On !active, go to REST.
    - On that transition edge, load pos_width, gap_width, neg_width and pulse_dac.
    - Assert meas_valid for the following cycle.
    - pulse_count++, saturating at all-ones.
    - If pos_cnt != neg_cnt, set fault_imbalance.
- Counter saturation:
  - All counters saturate at all-ones and never wrap.
  - A saturated pos/neg count still compares: two saturated values compare equal.
- Period measurement:
  - A free-running per_cnt increments every cycle and saturates.
  - On each REST→POS transition: if a previous start exists, period <= per_cnt + 1 and period_valid <= 1. per_cnt restarts at 0 in either case.
  - The first pulse after reset/clear produces no period.
- fault_short: set in any state and any cycle where (up_switches & down_switches) != 0.
- Sticky faults hold until clear or reset.
  - If clear and a fault-set condition occur in the same cycle, the set wins.
  - clear does not change the FSM, the width outputs or period.
- Reset asserted mid-pulse: everything returns to reset values immediately. The interrupted pulse is not reported.

Decomposition:
- Package aska_npg_pkg: FSM state encoding (2-bit REST/POS/GAP/NEG), default widths PH_W/PER_W/CNT_W and GAP_MAX, and the generator's switch/DAC widths, which the generator will also import.
- Sub-module aska_sat_counter: parameterised width, synchronous load/clear, enable, saturate at all-ones. Instantiated for pos, gap, neg, period and pulse counts.

Test Plan:
- Inputs up=0001/down=0010 for 3 cycles, then 0 for 1 cycle, then up=0010/down=0001 for 3 cycles, then 0 → single meas_valid; pos=3, gap=1, neg=3; pulse_count=1; no faults.
- Loopback with the generator: freq=400, phaseDuration=3, electrode1=0001, electrode2=0100, amplitude=20, ramp=0 → pos=3, gap=1, neg=3; from the second pulse, period=401 and period_valid=1; pulse_dac matches the generator DAC output.
- Positive phase 3 cycles, gap 1, negative phase 2 cycles → fault_imbalance=1, meas_valid still pulses. Then clear → fault_imbalance=0, pulse_count=0, period_valid=0.
- up=0011/down=0010 for one cycle → fault_short=1 on the next cycle and held; clear asserted in a cycle where the short persists → fault stays 1.
- Positive phase, then 15 idle cycles → fault_gap_timeout=1, no meas_valid, FSM back in REST. The next clean pulse is measured normally.
- Reset asserted during NEG → all outputs 0 the same cycle. After release, a pulse is measured correctly and period_valid=0 until the second pulse.
